// File: rtl/mix_pkg.sv
// Shared types and helpers for the mix_scheduler slice.
// saturate() is only referenced when MIX_SATURATE_EN is defined.
package mix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_MUL   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } mix_state_t;

  function automatic int gain_unity(input int bitsize);
    return 1 << (bitsize - 2);
  endfunction

  // Wide enough that summing CHANNELS full-scale terms cannot overflow.
  function automatic int acc_width(input int bitsize, input int channels);
    return bitsize + 2 + $clog2(channels);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int bitsize);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bitsize - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bitsize - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mix_mac.sv
// Registered signed BITSIZE x BITSIZE multiplier with Q1.(BITSIZE-2) scaling.
// One cycle from operands to term; sized to fit a single SB_MAC16.
module mix_mac #(
  parameter int BITSIZE = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic signed [BITSIZE-1:0] a,
  input  logic signed [BITSIZE-1:0] b,
  output logic signed [BITSIZE+1:0] term
);
  localparam int TW = BITSIZE + 2;

  logic signed [2*BITSIZE-1:0] prod_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      prod_q <= '0;
    end else if (en) begin
      prod_q <= a * b;
    end
  end

  assign term = TW'(prod_q >>> (BITSIZE - 2));

endmodule

// File: rtl/mix_scheduler.sv
// Frame-synchronous gain mixer sharing one multiplier across CHANNELS inputs.
// Define MIX_SATURATE_EN to clamp the mix instead of wrapping it.
module mix_scheduler
  import mix_pkg::*;
#(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 4
) (
  input  logic                          bclk,
  input  logic                          rstn,
  input  logic                          lrclk,
  input  logic [CHANNELS*BITSIZE-1:0]   in_bus,
  input  logic                          gain_wr_valid,
  output logic                          gain_wr_ready,
  input  logic [$clog2(CHANNELS)-1:0]   gain_wr_addr,
  input  logic [BITSIZE-1:0]            gain_wr_data,
  output logic [BITSIZE-1:0]            out,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun
);
  localparam int IW = $clog2(CHANNELS);
  localparam int TW = BITSIZE + 2;
  localparam int AW = acc_width(BITSIZE, CHANNELS);

  mix_state_t                  state;
  logic                        lrclk_q;
  logic                        frame_edge;
  logic [IW-1:0]               idx;
  logic [CHANNELS*BITSIZE-1:0] smp_q;
  logic signed [BITSIZE-1:0]   gain_sh  [CHANNELS];
  logic signed [BITSIZE-1:0]   gain_act [CHANNELS];
  logic signed [AW-1:0]        acc;
  logic signed [AW-1:0]        term_ext;
  logic signed [BITSIZE-1:0]   mac_a;
  logic signed [BITSIZE-1:0]   mac_b;
  logic signed [TW-1:0]        term;
  logic [BITSIZE-1:0]          mix_final;

  assign frame_edge    = lrclk & ~lrclk_q;
  assign busy          = (state != ST_IDLE);
  assign gain_wr_ready = (state != ST_LATCH);
  assign mac_a         = smp_q[idx*BITSIZE +: BITSIZE];
  assign mac_b         = gain_act[idx];
  assign term_ext      = {{(AW-TW){term[TW-1]}}, term};

`ifdef MIX_SATURATE_EN
  assign mix_final = BITSIZE'(saturate(64'(acc), BITSIZE));
`else
  assign mix_final = acc[BITSIZE-1:0];
`endif

  mix_mac #(.BITSIZE(BITSIZE)) u_mac (
    .clk  (bclk),
    .rstn (rstn),
    .en   (state == ST_MUL),
    .a    (mac_a),
    .b    (mac_b),
    .term (term)
  );

  // Shadow gains are writable in every state except LATCH, where they are copied.
  always_ff @(posedge bclk) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < CHANNELS; k++) gain_sh[k] <= '0;
    end else if (gain_wr_valid && gain_wr_ready) begin
      gain_sh[gain_wr_addr] <= gain_wr_data;
    end
  end

  always_ff @(posedge bclk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      lrclk_q   <= 1'b0;
      idx       <= '0;
      smp_q     <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) gain_act[k] <= '0;
    end else begin
      lrclk_q   <= lrclk;
      out_valid <= 1'b0;
      overrun   <= frame_edge && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (frame_edge) state <= ST_LATCH;
        end
        ST_LATCH: begin
          smp_q <= in_bus;
          for (int unsigned k = 0; k < CHANNELS; k++) gain_act[k] <= gain_sh[k];
          acc   <= '0;
          idx   <= '0;
          state <= ST_MUL;
        end
        ST_MUL: begin
          // The multiplier output lags by one cycle, so the first MUL has nothing to add.
          if (idx != '0) acc <= acc + term_ext;
          idx <= idx + 1'b1;
          if (idx == IW'(CHANNELS - 1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          acc   <= acc + term_ext;
          state <= ST_OUT;
        end
        ST_OUT: begin
          out       <= mix_final;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_scheduler.sv
// Scoreboard bench for mix_scheduler: a frame-level model predicts each mix,
// its due cycle, busy/ready/overrun, and a monitor compares as outputs appear.
module tb_mix_scheduler;
  localparam int W    = 16;
  localparam int C    = 4;
  localparam int AWID = $clog2(C);

  logic           bclk = 1'b0;
  logic           rstn = 1'b0;
  logic           lrclk = 1'b0;
  logic [C*W-1:0] in_bus = '0;
  logic           gain_wr_valid = 1'b0;
  logic           gain_wr_ready;
  logic [AWID-1:0] gain_wr_addr = '0;
  logic [W-1:0]   gain_wr_data = '0;
  logic [W-1:0]   out;
  logic           out_valid;
  logic           busy;
  logic           overrun;

  mix_scheduler #(.BITSIZE(W), .CHANNELS(C)) dut (
    .bclk          (bclk),
    .rstn          (rstn),
    .lrclk         (lrclk),
    .in_bus        (in_bus),
    .gain_wr_valid (gain_wr_valid),
    .gain_wr_ready (gain_wr_ready),
    .gain_wr_addr  (gain_wr_addr),
    .gain_wr_data  (gain_wr_data),
    .out           (out),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 bclk = ~bclk;

  typedef struct {
    logic [W-1:0] val;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  logic [W-1:0] m_gain [C];
  bit           m_active = 0;
  int           m_start = -100;
  int           m_ovr_at = -1;
  bit           m_lr_prev = 0;
  logic [W-1:0] m_hold = '0;
  int           n_valid = 0;
  int           n_ovr = 0;
  bit           checking = 0;

  // Gain-weighted sum of the snapshot using the model's current gains.
  function automatic logic [W-1:0] mix_ref(input logic [C*W-1:0] bus);
    longint sum = 0;
    for (int k = 0; k < C; k++) begin
      logic [W-1:0] sv;
      logic [W-1:0] gv;
      longint s;
      longint g;
      sv = bus[k*W +: W];
      gv = m_gain[k];
      s = longint'(signed'(sv));
      g = longint'(signed'(gv));
      sum += (s * g) >>> (W - 2);
    end
`ifdef MIX_SATURATE_EN
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
`endif
    return sum[W-1:0];
  endfunction

  task automatic check1(input string nm, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b required=%b", nm, cyc, act, req);
    end
  endtask

  task automatic check16(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h required=%h", nm, cyc, act, req);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  // Reference model: frame acceptance window, gain shadow, snapshot in LATCH.
  initial forever begin
    @(posedge bclk);
    cyc++;
    if (!rstn) begin
      m_active  = 0;
      m_lr_prev = 0;
      m_ovr_at  = -1;
      m_hold    = '0;
      sb.delete();
      foreach (m_gain[k]) m_gain[k] = '0;
    end else begin
      bit   edge_seen;
      exp_t e;
      if (m_active && cyc == m_start + 1) begin
        e.val = mix_ref(in_bus);
        e.due = m_start + C + 3;
        sb.push_back(e);
      end
      edge_seen = lrclk && !m_lr_prev;
      m_lr_prev = lrclk;
      if (edge_seen) begin
        if (m_active && cyc <= m_start + C + 3) m_ovr_at = cyc;
        else begin
          m_active = 1;
          m_start  = cyc;
        end
      end
      if (gain_wr_valid && !(m_active && cyc == m_start + 1))
        m_gain[gain_wr_addr] = gain_wr_data;
    end
  end

  // Monitor on the falling edge.
  initial forever begin
    @(negedge bclk);
    if (checking) begin
      bit   exp_busy;
      bit   exp_ready;
      exp_t e;
      exp_busy  = m_active && cyc >= m_start && cyc <= m_start + C + 2;
      exp_ready = !(m_active && cyc == m_start);
      check1("busy", busy, exp_busy);
      check1("gain_wr_ready", gain_wr_ready, exp_ready);
      check1("overrun", overrun, cyc == m_ovr_at);
      if (overrun === 1'b1) n_ovr++;
      if (out_valid === 1'b1) begin
        n_valid++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_valid_unexpected cyc=%0d got=pulse out=%h required=no pulse", cyc, out);
        end else begin
          e = sb.pop_front();
          check16("mix_value", out, e.val);
          check_int("mix_latency", cyc, e.due);
          m_hold = e.val;
        end
      end else begin
        if (sb.size() != 0 && cyc >= sb[0].due) begin
          e = sb.pop_front();
          tests++;
          fails++;
          $display("FAIL out_valid_missing cyc=%0d got=none required=pulse with %h", cyc, e.val);
          m_hold = e.val;
        end
        check16("out_hold", out, m_hold);
      end
    end
  end

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    gain_wr_valid = 1'b1;
    gain_wr_addr  = AWID'(a);
    gain_wr_data  = d;
    tick();
    gain_wr_valid = 1'b0;
  endtask

  task automatic set_all_gains(input logic [W-1:0] d);
    for (int k = 0; k < C; k++) wr(k, d);
  endtask

  function automatic logic [C*W-1:0] rep(input logic [W-1:0] s);
    return {C{s}};
  endfunction

  task automatic start_frame(input logic [C*W-1:0] bus);
    in_bus = bus;
    lrclk  = 1'b1;
    tick();
    lrclk  = 1'b0;
  endtask

  task automatic settle();
    repeat (C + 6) tick();
    check_int("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic expect_out(input string nm, input logic [W-1:0] v);
    @(negedge bclk);
    check16(nm, out, v);
  endtask

  initial begin
    int nv;
    int no;
    repeat (3) tick();
    checking = 1;
    rstn = 1'b1;
    tick();
    expect_out("reset_out", 16'h0000);

    wr(0, 16'h4000);
    start_frame({48'h0, 16'h1234});
    settle();
    expect_out("unity_ch0", 16'h1234);

    set_all_gains(16'h2000);
    start_frame(rep(16'h1000));
    settle();
    expect_out("half_gain", 16'h2000);

    set_all_gains(16'h4000);
    start_frame(rep(16'h7000));
    settle();
`ifdef MIX_SATURATE_EN
    expect_out("overflow_pos", 16'h7FFF);
`else
    expect_out("overflow_pos", 16'hC000);
`endif
    start_frame(rep(16'h9000));
    settle();
`ifdef MIX_SATURATE_EN
    expect_out("overflow_neg", 16'h8000);
`else
    expect_out("overflow_neg", 16'h4000);
`endif

    // Late write lands in the following frame.
    set_all_gains(16'h0000);
    start_frame({48'h0, 16'h0100});
    tick();
    tick();
    wr(0, 16'h4000);
    settle();
    expect_out("late_write_frame_a", 16'h0000);
    start_frame({48'h0, 16'h0100});
    settle();
    expect_out("late_write_frame_b", 16'h0100);

    // Write held through LATCH: stalled one cycle, then accepted for the next frame.
    in_bus = {32'h0, 16'h0200, 16'h0100};
    lrclk = 1'b1;
    tick();
    lrclk = 1'b0;
    gain_wr_valid = 1'b1;
    gain_wr_addr  = AWID'(1);
    gain_wr_data  = 16'h4000;
    @(negedge bclk);
    check1("ready_in_latch", gain_wr_ready, 1'b0);
    tick();
    @(negedge bclk);
    check1("ready_after_latch", gain_wr_ready, 1'b1);
    tick();
    gain_wr_valid = 1'b0;
    settle();
    expect_out("latch_write_frame_a", 16'h0100);
    start_frame({32'h0, 16'h0200, 16'h0100});
    settle();
    expect_out("latch_write_frame_b", 16'h0300);

    // Second edge mid-frame, plus input change after LATCH.
    nv = n_valid;
    no = n_ovr;
    start_frame(rep(16'h0011));
    tick();
    in_bus = {$urandom, $urandom};
    tick();
    lrclk = 1'b1;
    tick();
    lrclk = 1'b0;
    settle();
    expect_out("overrun_frame_value", 16'h0022);
    check_int("overrun_pulses", n_ovr - no, 1);
    check_int("overrun_valids", n_valid - nv, 1);

    // Reset in the middle of MUL.
    set_all_gains(16'h4000);
    start_frame(rep(16'h0100));
    repeat (3) tick();
    rstn = 1'b0;
    tick();
    @(negedge bclk);
    check1("reset_busy", busy, 1'b0);
    check1("reset_out_valid", out_valid, 1'b0);
    check16("reset_mid_out", out, 16'h0000);
    rstn = 1'b1;
    tick();
    nv = n_valid;
    start_frame(rep(16'h0100));
    settle();
    expect_out("post_reset_muted", 16'h0000);
    check_int("post_reset_valids", n_valid - nv, 1);

    // Randomized traffic: gain writes at any time, edges sometimes too close.
    for (int i = 0; i < 2000; i++) begin
      in_bus = {$urandom, $urandom};
      gain_wr_valid = ($urandom_range(0, 3) == 0);
      gain_wr_addr  = AWID'($urandom_range(0, C - 1));
      case ($urandom_range(0, 4))
        0: gain_wr_data = 16'h4000;
        1: gain_wr_data = 16'hC000;
        2: gain_wr_data = 16'h7FFF;
        3: gain_wr_data = 16'h8000;
        default: gain_wr_data = W'($urandom);
      endcase
      if ($urandom_range(0, 5) == 0) lrclk = ~lrclk;
      tick();
    end
    gain_wr_valid = 1'b0;
    lrclk = 1'b0;
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
